// File: rtl/iob_axi2mem.sv
// iob_axi2mem: AXI4 subordinate replaying bursts as single-word req/gnt/rvalid memory accesses
module iob_axi2mem #(
   parameter int AXI_ID_W   = 1,
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_LEN_W  = 8
) (
   input  logic                    clk_i,
   input  logic                    cke_i,
   input  logic                    arst_n_i,
   input  logic                    awvalid_i,
   output logic                    awready_o,
   input  logic [AXI_ID_W-1:0]     awid_i,
   input  logic [AXI_ADDR_W-1:0]   awaddr_i,
   input  logic [AXI_LEN_W-1:0]    awlen_i,
   input  logic [1:0]              awburst_i,
   input  logic                    wvalid_i,
   output logic                    wready_o,
   input  logic [AXI_DATA_W-1:0]   wdata_i,
   input  logic [AXI_DATA_W/8-1:0] wstrb_i,
   input  logic                    wlast_i,
   output logic                    bvalid_o,
   input  logic                    bready_i,
   output logic [AXI_ID_W-1:0]     bid_o,
   output logic [1:0]              bresp_o,
   input  logic                    arvalid_i,
   output logic                    arready_o,
   input  logic [AXI_ID_W-1:0]     arid_i,
   input  logic [AXI_ADDR_W-1:0]   araddr_i,
   input  logic [AXI_LEN_W-1:0]    arlen_i,
   input  logic [1:0]              arburst_i,
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [AXI_ID_W-1:0]     rid_o,
   output logic [AXI_DATA_W-1:0]   rdata_o,
   output logic [1:0]              rresp_o,
   output logic                    rlast_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [AXI_DATA_W/8-1:0] mem_be_o,
   output logic [AXI_ADDR_W-3:0]   mem_addr_o,
   output logic [AXI_DATA_W-1:0]   mem_wdata_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic                    mem_err_i,
   input  logic [AXI_DATA_W-1:0]   mem_rdata_i
);
   localparam int WA = AXI_ADDR_W - 2;
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP} state_t;
   state_t state, nxt;
   logic [AXI_ID_W-1:0] id;
   logic [WA-1:0] addr;
   logic [AXI_LEN_W-1:0] len, beat;
   logic [AXI_DATA_W-1:0] data;
   logic [AXI_DATA_W/8-1:0] strb;
   logic err, last_wr, fixed, last, step, unused;
   assign unused = ^{wlast_i, awaddr_i[1:0], araddr_i[1:0]};
   assign arready_o = arst_n_i & (state == IDLE) & arvalid_i & (~awvalid_i | last_wr);
   assign awready_o = arst_n_i & (state == IDLE) & awvalid_i & (~arvalid_i | ~last_wr);
   assign last = beat == len;
   assign step = (state == RD_RESP & rready_i & ~last) | (state == WR_WAIT & mem_rvalid_i & ~last);
   // state register
   always_ff @(posedge clk_i or negedge arst_n_i)
      if (!arst_n_i) state <= IDLE;
      else if (cke_i) state <= nxt;
   // next-state decode
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = arready_o ? RD_REQ : awready_o ? WR_DATA : IDLE;
         RD_REQ:  nxt = mem_gnt_i ? RD_WAIT : RD_REQ;
         RD_WAIT: nxt = mem_rvalid_i ? RD_RESP : RD_WAIT;
         RD_RESP: nxt = !rready_i ? RD_RESP : last ? IDLE : RD_REQ;
         WR_DATA: nxt = wvalid_i ? WR_REQ : WR_DATA;
         WR_REQ:  nxt = mem_gnt_i ? WR_WAIT : WR_REQ;
         WR_WAIT: nxt = !mem_rvalid_i ? WR_WAIT : last ? WR_RESP : WR_DATA;
         WR_RESP: nxt = bready_i ? IDLE : WR_RESP;
         default: nxt = IDLE;
      endcase
   end
   // burst context, beat data and error capture
   always_ff @(posedge clk_i or negedge arst_n_i)
      if (!arst_n_i) begin
         id      <= '0;
         addr    <= '0;
         len     <= '0;
         beat    <= '0;
         data    <= '0;
         strb    <= '0;
         err     <= 1'b0;
         last_wr <= 1'b0;
         fixed   <= 1'b0;
      end else if (cke_i) begin
         if (arready_o | awready_o) begin
            id      <= arready_o ? arid_i : awid_i;
            addr    <= arready_o ? araddr_i[AXI_ADDR_W-1:2] : awaddr_i[AXI_ADDR_W-1:2];
            len     <= arready_o ? arlen_i : awlen_i;
            fixed   <= (arready_o ? arburst_i : awburst_i) == 2'b00;
            beat    <= '0;
            err     <= 1'b0;
            last_wr <= awready_o;
         end
         if (state == RD_WAIT && mem_rvalid_i) begin
            data <= mem_rdata_i;
            err  <= mem_err_i;
         end
         if (state == WR_DATA && wvalid_i) begin
            data <= wdata_i;
            strb <= wstrb_i;
         end
         if (state == WR_WAIT && mem_rvalid_i) err <= err | mem_err_i;
         if (step) begin
            beat <= beat + 1'b1;
            addr <= addr + WA'(!fixed);
         end
      end
   // outputs decoded from registered state only
   always_comb begin
      mem_req_o   = state == RD_REQ || state == WR_REQ;
      mem_we_o    = state == WR_REQ;
      mem_be_o    = state == RD_REQ ? '1 : state == WR_REQ ? strb : '0;
      mem_addr_o  = mem_req_o ? addr : '0;
      mem_wdata_o = mem_we_o ? data : '0;
      wready_o    = state == WR_DATA;
      rvalid_o    = state == RD_RESP;
      rid_o       = rvalid_o ? id : '0;
      rdata_o     = rvalid_o ? data : '0;
      rresp_o     = rvalid_o && err ? 2'b10 : 2'b00;
      rlast_o     = rvalid_o && last;
      bvalid_o    = state == WR_RESP;
      bid_o       = bvalid_o ? id : '0;
      bresp_o     = bvalid_o && err ? 2'b10 : 2'b00;
   end
endmodule
